// File: rtl/relm_uart_tx_io.sv
// ReLM push-channel consumer: buffers the low byte of each accepted push in a
// small FIFO and sends it as 8N1 serial on txd, asking the PE to retry while full.
module relm_uart_tx_io #(
    parameter int WD           = 32,
    parameter int WAD          = 4,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [WD:0] push_d,
    output logic        push_retry,
    output logic        txd,
    output logic        tx_idle
);

    localparam int DEPTH = 2 ** WAD;
    localparam int CW    = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       mem_q [DEPTH];
    logic [WAD-1:0]   wr_ptr_q, wr_ptr_d;
    logic [WAD-1:0]   rd_ptr_q, rd_ptr_d;
    logic [WAD:0]     count_q, count_d;
    logic [CW-1:0]    baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;

    logic             full;
    logic             wr_en;
    logic             pop;
    logic             baud_wrap;
    logic             fifo_nonempty;
    logic             unused_push_bits;

    // Only the low byte is transmitted; the rest of the channel word is ignored.
    assign unused_push_bits = ^push_d[WD-1:8];

    // Retry is a pure decode of registered count so it never loops back through push_d.
    assign full          = (count_q == (WAD+1)'(DEPTH));
    assign fifo_nonempty = (count_q != '0);
    assign wr_en         = push_d[WD] && !full;
    assign baud_wrap     = (baud_q == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    txd_d   = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    txd_d   = shift_q[0];
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_DATA: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        // Next bit is the one that becomes shift[0] after this shift.
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        txd_d   = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_STOP: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (fifo_nonempty) begin
                        // Chain straight into the next start bit: no idle gap.
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        txd_d   = 1'b0;
                        state_d = S_START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                txd_d   = 1'b1;
                baud_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + WAD'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + WAD'(1);
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + (WAD+1)'(1);
            2'b01:   count_d = count_q - (WAD+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            txd_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_d[7:0];
        end
    end

    assign txd        = txd_q;
    assign push_retry = full;
    assign tx_idle    = (state_q == S_IDLE) && !fifo_nonempty;

endmodule

// File: tb/tb_relm_uart_tx_io.sv
// Bench for relm_uart_tx_io: random pushes checked cycle by cycle against a
// frame-timeline model of the FIFO and the serial waveform.
module tb_relm_uart_tx_io;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;
    localparam int CPB2  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [32:0] push_d  = '0;
    logic [32:0] push_d2 = '0;
    logic        push_retry, txd, tx_idle;
    logic        push_retry2, txd2, tx_idle2;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: queue of bytes held in the FIFO, plus the frame currently on the line.
    logic [7:0] exp_q[$];
    bit         m_busy = 1'b0;
    int         m_t    = 0;
    logic [7:0] m_cur  = 8'h00;

    relm_uart_tx_io #(.WD(32), .WAD(2), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .push_d     (push_d),
        .push_retry (push_retry),
        .txd        (txd),
        .tx_idle    (tx_idle)
    );

    relm_uart_tx_io #(.WD(32), .WAD(2), .CLKS_PER_BIT(CPB2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .push_d     (push_d2),
        .push_retry (push_retry2),
        .txd        (txd2),
        .tx_idle    (tx_idle2)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic model_txd();
        int b;
        if (!m_busy) return 1'b1;
        b = m_t / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_cur[b-1];
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_busy = 1'b0;
        m_t    = 0;
    endtask

    // One clock edge: a frame starts whenever the line is free and a byte waits.
    task automatic model_edge(input logic stb, input logic [7:0] b);
        bit full;
        bit wr;
        bit pop;
        full = (exp_q.size() == DEPTH);
        wr   = stb && !full;
        pop  = (exp_q.size() > 0) && (!m_busy || m_t == FRAME - 1);
        if (m_busy && m_t != FRAME - 1) begin
            m_t++;
        end else if (pop) begin
            m_cur  = exp_q.pop_front();
            m_busy = 1'b1;
            m_t    = 0;
        end else begin
            m_busy = 1'b0;
        end
        if (wr) exp_q.push_back(b);
    endtask

    task automatic check_outputs();
        check_eq("txd", txd, model_txd());
        check_eq("push_retry", push_retry, exp_q.size() == DEPTH);
        check_eq("tx_idle", tx_idle, !m_busy && exp_q.size() == 0);
    endtask

    task automatic cycle(input logic stb, input logic [31:0] word);
        push_d = {stb, word};
        @(posedge clk);
        model_edge(stb, word[7:0]);
        @(negedge clk);
        push_d = '0;
        check_outputs();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0);
    endtask

    initial begin
        int guard;
        int k;
        int b;
        logic e;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_txd", txd, 1'b1);
        check_eq("reset_retry", push_retry, 1'b0);
        check_eq("reset_idle", tx_idle, 1'b1);
        check_eq("reset_txd2", txd2, 1'b1);
        check_eq("reset_idle2", tx_idle2, 1'b1);
        rst = 1'b0;
        model_reset();

        // Single 0x55 frame; idle exactly when the stop bit completes.
        cycle(1'b1, 32'h0000_0055);
        idle_cycles(40);
        check_eq("t1_busy_at_40", tx_idle, 1'b0);
        idle_cycles(1);
        check_eq("t1_idle_at_41", tx_idle, 1'b1);
        idle_cycles(4);

        // Upper channel bits must not reach the line.
        cycle(1'b1, 32'hFFFF_FF41);
        idle_cycles(FRAME + 4);

        // Six back-to-back pushes: the sixth meets a full FIFO.
        for (int i = 0; i < 5; i++) cycle(1'b1, $urandom);
        check_eq("t3_retry_full", push_retry, 1'b1);
        cycle(1'b1, 32'h0000_00C3);
        guard = 0;
        while (exp_q.size() == DEPTH && guard < 200) begin
            cycle(1'b0, 32'h0);
            guard++;
        end
        check_eq("t3_slot_freed", guard < 200, 1'b1);
        check_eq("t3_retry_free", push_retry, 1'b0);
        cycle(1'b1, 32'h0000_003C);
        idle_cycles(6 * FRAME);

        // Strobe on the very cycle the FSM pops from a full FIFO.
        for (int i = 0; i < 5; i++) cycle(1'b1, $urandom);
        guard = 0;
        while (!(m_busy && m_t == FRAME - 1) && guard < 200) begin
            cycle(1'b0, 32'h0);
            guard++;
        end
        check_eq("t4_reach_pop", guard < 200, 1'b1);
        check_eq("t4_retry_before", push_retry, 1'b1);
        cycle(1'b1, 32'h0000_0099);
        check_eq("t4_retry_after_pop", push_retry, 1'b0);
        cycle(1'b1, 32'h0000_0066);
        check_eq("t4_refilled", push_retry, 1'b1);
        idle_cycles(6 * FRAME);

        // Random traffic with frequent backpressure.
        for (int i = 0; i < 800; i++) cycle($urandom_range(0, 9) == 0, $urandom);
        idle_cycles(6 * FRAME);

        // Reset in the middle of data bit 3 of 0xA5 while the FIFO is full.
        cycle(1'b1, 32'h0000_00A5);
        for (int i = 0; i < 4; i++) cycle(1'b1, $urandom);
        guard = 0;
        while (m_t != 17 && guard < 100) begin
            cycle(1'b0, 32'h0);
            guard++;
        end
        check_eq("t5_reach_bit3", guard < 100, 1'b1);
        check_eq("t5_txd_low_before", txd, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("t5_rst_txd", txd, 1'b1);
        check_eq("t5_rst_idle", tx_idle, 1'b1);
        check_eq("t5_rst_retry", push_retry, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_eq("t5_hold_txd", txd, 1'b1);
        rst = 1'b0;
        idle_cycles(3 * FRAME);
        cycle(1'b1, 32'h0000_0033);
        idle_cycles(FRAME + 4);

        // CLKS_PER_BIT=2 instance: 0x00 then 0xFF, 20-clk frames back to back.
        push_d2 = {1'b1, 32'h0000_0000};
        @(posedge clk);
        @(negedge clk);
        push_d2 = {1'b1, 32'hABCD_EFFF};
        @(posedge clk);
        @(negedge clk);
        push_d2 = '0;
        for (k = 0; k < 46; k++) begin
            if (k < 20) begin
                b = k / CPB2;
                e = (b == 9);
            end else if (k < 40) begin
                b = (k - 20) / CPB2;
                e = (b != 0);
            end else begin
                e = 1'b1;
            end
            check_eq($sformatf("t6_txd2_k%0d", k), txd2, e);
            check_eq($sformatf("t6_idle2_k%0d", k), tx_idle2, k >= 40);
            @(posedge clk);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
